// File: rtl/regfile_sb_pkg.sv
// Shared RV32I decode/writeback types used by the register file and its scoreboard.
package rv32i_types;
  localparam int NUM_REGS = 32;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic     we;
    reg_idx_t rd;
    logic [31:0] v;
  } wb_bus_t;
endpackage

// File: rtl/regfile_pend_cnt.sv
// Saturating up/down pending-writer counter for one architectural register.
// err pulses in any cycle whose net update would leave the range [0, 2^CNT_W-1].
module regfile_pend_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec_a,
  input  logic             dec_b,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);
  localparam logic signed [CNT_W+1:0] MAX_S = (CNT_W+2)'((1 << CNT_W) - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic signed [CNT_W+1:0] w_net;
  logic                    w_under;
  logic                    w_over;

  assign w_net   = $signed({2'b00, r_cnt})
                 + $signed({{(CNT_W+1){1'b0}}, inc})
                 - $signed({{(CNT_W+1){1'b0}}, dec_a})
                 - $signed({{(CNT_W+1){1'b0}}, dec_b});
  assign w_under = w_net < 0;
  assign w_over  = w_net > MAX_S;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_under) begin
      r_cnt <= '0;
    end else if (w_over) begin
      r_cnt <= MAX_S[CNT_W-1:0];
    end else begin
      r_cnt <= w_net[CNT_W-1:0];
    end
  end

  assign cnt = r_cnt;
  assign err = w_under | w_over;
endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file with a per-register pending-writer scoreboard.
// Optional macro REGFILE_BYPASS_EN: write-through read bypass and writeback-cycle unstall.
module regfile_sb
  import rv32i_types::*;
#(
  parameter int CNT_W = 2,
  parameter int NREG  = NUM_REGS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_s,
  input  logic [4:0]  rs2_s,
  output logic [31:0] rs1_v,
  output logic [31:0] rs2_v,
  output logic        rs1_busy,
  output logic        rs2_busy,
  input  logic        issue,
  input  logic [4:0]  issue_rd,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_v,
  input  logic        kill,
  input  logic [4:0]  kill_rd,
  output logic        sb_err
);
  logic [31:0]                 r_regs [1:NREG-1];
  logic                        r_sb_err;
  wb_bus_t                     w_wb;
  logic [NREG-1:0][CNT_W-1:0]  w_pend;
  logic [NREG-1:0]             w_err;

  assign w_wb = '{we: wb_we, rd: wb_rd, v: wb_v};

  // x0 has no counter: it can never be pending and never flags an error.
  assign w_pend[0] = '0;
  assign w_err[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    regfile_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (issue    && (issue_rd == reg_idx_t'(r))),
      .dec_a (w_wb.we  && (w_wb.rd  == reg_idx_t'(r))),
      .dec_b (kill     && (kill_rd  == reg_idx_t'(r))),
      .cnt   (w_pend[r]),
      .err   (w_err[r])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NREG; r++) begin
        r_regs[r] <= '0;
      end
    end else if (w_wb.we && (w_wb.rd != '0)) begin
      r_regs[w_wb.rd] <= w_wb.v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_err <= 1'b0;
    end else if (|w_err) begin
      r_sb_err <= 1'b1;
    end
  end

  function automatic logic [31:0] read_val(input reg_idx_t s);
    if (s == '0) begin
      return '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (w_wb.we && (w_wb.rd == s)) begin
      return w_wb.v;
    end
`endif
    return r_regs[s];
  endfunction

  function automatic logic busy_of(input reg_idx_t s);
`ifdef REGFILE_BYPASS_EN
    int dec;
`endif
    if (s == '0) begin
      return 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    // Floored (pend - dec) is non-zero exactly when pend exceeds dec.
    dec = int'(w_wb.we && (w_wb.rd == s)) + int'(kill && (kill_rd == s));
    return int'(w_pend[s]) > dec;
`else
    return w_pend[s] != '0;
`endif
  endfunction

  always_comb begin
    rs1_v    = read_val(rs1_s);
    rs2_v    = read_val(rs2_s);
    rs1_busy = busy_of(rs1_s);
    rs2_busy = busy_of(rs2_s);
  end

  assign sb_err = r_sb_err;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb against a behavioural register/scoreboard model.
module tb_regfile_sb;
  localparam int PMAX = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1_s = '0, rs2_s = '0, issue_rd = '0, wb_rd = '0, kill_rd = '0;
  logic        issue = 1'b0, wb_we = 1'b0, kill = 1'b0;
  logic [31:0] wb_v = '0;
  logic [31:0] rs1_v, rs2_v;
  logic        rs1_busy, rs2_busy, sb_err;

  int total = 0;
  int bad = 0;

  // Reference state: architectural values, in-flight writer counts, sticky error.
  logic [31:0] m_reg [32];
  int          m_pend [32];
  logic        m_err;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_s(rs1_s), .rs2_s(rs2_s), .rs1_v(rs1_v), .rs2_v(rs2_v),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue(issue), .issue_rd(issue_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_v(wb_v),
    .kill(kill), .kill_rd(kill_rd),
    .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_reg[r]  = '0;
      m_pend[r] = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [31:0] exp_val(input logic [4:0] s);
    if (s == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wb_we && wb_rd == s) return wb_v;
`endif
    return m_reg[s];
  endfunction

  function automatic logic exp_busy(input logic [4:0] s);
    int left;
    if (s == 0) return 1'b0;
    left = m_pend[s];
`ifdef REGFILE_BYPASS_EN
    if (wb_we && wb_rd == s) left = left - 1;
    if (kill && kill_rd == s) left = left - 1;
`endif
    return left > 0;
  endfunction

  task automatic idle();
    issue = 1'b0; wb_we = 1'b0; kill = 1'b0;
  endtask

  // Let combinational outputs settle after input changes and compare every output.
  task automatic settle();
    #1;
    chk("rs1_v", rs1_v, exp_val(rs1_s));
    chk("rs2_v", rs2_v, exp_val(rs2_s));
    chk("rs1_busy", 32'(rs1_busy), 32'(exp_busy(rs1_s)));
    chk("rs2_busy", 32'(rs2_busy), 32'(exp_busy(rs2_s)));
    chk("sb_err", 32'(sb_err), 32'(m_err));
  endtask

  // Advance one clock and apply the same-cycle issue/wb/kill to the model.
  task automatic tick();
    int n;
    @(posedge clk);
    if (rst_n) begin
      for (int r = 1; r < 32; r++) begin
        n = m_pend[r];
        if (issue && issue_rd == r) n++;
        if (wb_we && wb_rd == r) n--;
        if (kill && kill_rd == r) n--;
        if (n < 0) begin n = 0; m_err = 1'b1; end
        if (n > PMAX) begin n = PMAX; m_err = 1'b1; end
        m_pend[r] = n;
      end
      if (wb_we && wb_rd != 0) m_reg[wb_rd] = wb_v;
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    settle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rs1_s = 5'd5;
    #2;
    settle();
    @(negedge clk);
    rst_n = 1'b1;

    // Write x5, then asynchronous reset mid-cycle discards it.
    wb_we = 1'b1; wb_rd = 5'd5; wb_v = 32'hDEADBEEF; step(); idle();
    rs1_s = 5'd5; settle(); chk("x5_written", rs1_v, 32'hDEADBEEF);
    #2; rst_n = 1'b0; #1;
    model_reset();
    chk("x5_after_reset", rs1_v, 32'h0);
    chk("busy_after_reset", 32'(rs1_busy), 32'h0);
    chk("err_after_reset", 32'(sb_err), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // x0 ignores writes and issues.
    wb_we = 1'b1; wb_rd = 5'd0; wb_v = 32'h1234; rs1_s = 5'd0; step(); idle();
    settle(); chk("x0_reads_zero", rs1_v, 32'h0);
    issue = 1'b1; issue_rd = 5'd0; step(); idle();
    settle(); chk("x0_never_busy", 32'(rs1_busy), 32'h0);

    // RAW hazard on x7.
    issue = 1'b1; issue_rd = 5'd7; step(); idle();
    rs2_s = 5'd7; settle(); chk("x7_busy", 32'(rs2_busy), 32'h1); tick();
    wb_we = 1'b1; wb_rd = 5'd7; wb_v = 32'hA5A5A5A5; settle();
`ifdef REGFILE_BYPASS_EN
    chk("x7_bypass_v", rs2_v, 32'hA5A5A5A5);
    chk("x7_wb_cycle_busy", 32'(rs2_busy), 32'h0);
`else
    chk("x7_wb_cycle_busy", 32'(rs2_busy), 32'h1);
`endif
    tick(); idle();
    settle(); chk("x7_after_v", rs2_v, 32'hA5A5A5A5); chk("x7_after_busy", 32'(rs2_busy), 32'h0);
    tick();

    // Three in-flight writers to x3.
    rs1_s = 5'd3;
    issue = 1'b1; issue_rd = 5'd3; step(); step(); step(); idle();
    wb_we = 1'b1; wb_rd = 5'd3; wb_v = 32'h11; step(); wb_v = 32'h22; step(); idle();
    settle(); chk("x3_busy_after_two_wb", 32'(rs1_busy), 32'h1); tick();
    wb_we = 1'b1; wb_rd = 5'd3; wb_v = 32'h33; step(); idle();
    settle(); chk("x3_clear", 32'(rs1_busy), 32'h0); chk("x3_val", rs1_v, 32'h33); tick();
    // Overflow: fourth issue saturates and sets sb_err.
    issue = 1'b1; issue_rd = 5'd3; step(); step(); step();
    settle(); chk("err_before_ovf", 32'(sb_err), 32'h0); tick(); idle();
    settle(); chk("err_ovf", 32'(sb_err), 32'h1); tick();
    wb_we = 1'b1; wb_rd = 5'd3; step(); step(); idle();
    settle(); chk("x3_held_busy", 32'(rs1_busy), 32'h1); tick();
    wb_we = 1'b1; wb_rd = 5'd3; step(); idle();
    settle(); chk("x3_held_clear", 32'(rs1_busy), 32'h0); tick();

    // Kill path and underflow.
    do_reset();
    rs1_s = 5'd9;
    wb_we = 1'b1; wb_rd = 5'd9; wb_v = 32'h55; step(); idle();
    issue = 1'b1; issue_rd = 5'd9; step(); idle();
    settle(); chk("x9_busy", 32'(rs1_busy), 32'h1); tick();
    kill = 1'b1; kill_rd = 5'd9; step(); idle();
    settle(); chk("x9_kill_clear", 32'(rs1_busy), 32'h0); chk("x9_keeps", rs1_v, 32'h55); tick();
    kill = 1'b1; kill_rd = 5'd9; step(); idle();
    settle(); chk("err_underflow", 32'(sb_err), 32'h1); tick();

    // Simultaneous issue and writeback to x4 with one writer outstanding.
    do_reset();
    rs2_s = 5'd4;
    issue = 1'b1; issue_rd = 5'd4; step();
    wb_we = 1'b1; wb_rd = 5'd4; wb_v = 32'h44; step(); idle();
    settle(); chk("x4_still_busy", 32'(rs2_busy), 32'h1); tick();
    wb_we = 1'b1; wb_rd = 5'd4; wb_v = 32'h45; step(); idle();
    settle(); chk("x4_clear", 32'(rs2_busy), 32'h0); chk("x4_err_clean", 32'(sb_err), 32'h0); tick();

    // Randomized traffic over a small register window to force collisions.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rs1_s    = 5'($urandom_range(0, 7));
      rs2_s    = 5'($urandom_range(0, 7));
      issue    = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, 7));
      wb_we    = 1'($urandom_range(0, 1));
      wb_rd    = 5'($urandom_range(0, 7));
      wb_v     = $urandom;
      kill     = ($urandom_range(0, 3) == 0);
      kill_rd  = 5'($urandom_range(0, 7));
      if (i == 200) begin
        #2; rst_n = 1'b0; #1;
        model_reset();
        idle();
        settle();
        @(negedge clk); rst_n = 1'b1;
      end else begin
        step();
      end
    end
    idle();
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
